// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD sector scheduler:
//   - FSM state encoding (IDLE, ISSUE, WAIT_BLK, GAP, FINISH)
//   - block size and sector address width
//   - requester id type and a helper to name the other requester
// ---------------------------------------------------------------------------
package sd_pkg;

  localparam int SD_SEC_W     = 32;
  localparam int SD_BLK_BYTES = 512;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE    = 3'd1;
  localparam logic [2:0] ST_WAIT_BLK = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;

  typedef enum logic {
    REQ_ID0 = 1'b0,
    REQ_ID1 = 1'b1
  } req_id_t;

  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_ID0) ? REQ_ID1 : REQ_ID0;
  endfunction

endpackage

// File: rtl/sd_rr_arb2.sv
// ---------------------------------------------------------------------------
// sd_rr_arb2
// Two-way round-robin arbiter. The pointer names the requester that is
// favoured when both request; it moves to the other requester whenever a
// job is released, so the requester served last loses the next tie.
// Ports:
//   clk, srst     clock, synchronous active-high reset (pointer -> 0)
//   req[1:0]      request levels, bit i = requester i
//   release_stb   1-cycle strobe: the job of release_id has finished
//   release_id    owner of the job being released
//   gnt_valid     at least one requester is asking
//   gnt_id        requester that wins this cycle (valid with gnt_valid)
// ---------------------------------------------------------------------------
module sd_rr_arb2
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       release_stb,
  input  req_id_t    release_id,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  req_id_t ptr_reg;
  logic    ptr_bit;

  assign ptr_bit = (ptr_reg == REQ_ID1);

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= REQ_ID0;
    end else if (release_stb) begin
      ptr_reg <= other_id(release_id);
    end
  end

  always_comb begin
    gnt_valid = |req;
    gnt_id    = ptr_reg;
    // Favoured requester idle: the other one takes the reader.
    if (!req[ptr_bit]) begin
      gnt_id = other_id(ptr_reg);
    end
  end

endmodule

// File: rtl/sd_sector_sched.sv
// ---------------------------------------------------------------------------
// sd_sector_sched
// Shares one single-block SD sector reader between two picture-load
// requesters. A granted job is walked sector by sector: one block read per
// sector, a recovery gap after every block, a per-block timeout and a
// bounded number of retries. Received bytes are packed big-end-first into
// 16-bit words tagged with the owning requester.
// Ports:
//   SD_clk, SD_rst              clock, synchronous active-high reset
//   reqN_i/reqN_sec_i/reqN_len_i job request level, start sector, count
//   gntN_o                      requester N's job owns the reader
//   doneN_o                     1-cycle pulse at the end of N's job
//   rd_start_o / rd_sec_o       block-read command and its sector
//   rd_byte_i/rd_byte_valid_i   byte stream from the reader
//   rd_done_i                   reader finished the block
//   word_o/word_valid_o/word_src_o packed output word, owner tag
//   busy_o                      scheduler not idle
//   err_o                       sticky abort flag (cleared on next grant)
// ---------------------------------------------------------------------------
module sd_sector_sched
  import sd_pkg::*;
#(
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 200000,
  parameter int MAX_RETRY   = 3,
  parameter int BLK_BYTES   = SD_BLK_BYTES
) (
  input  logic                SD_clk,
  input  logic                SD_rst,
  input  logic                req0_i,
  input  logic [SD_SEC_W-1:0] req0_sec_i,
  input  logic [11:0]         req0_len_i,
  output logic                gnt0_o,
  output logic                done0_o,
  input  logic                req1_i,
  input  logic [SD_SEC_W-1:0] req1_sec_i,
  input  logic [11:0]         req1_len_i,
  output logic                gnt1_o,
  output logic                done1_o,
  output logic                rd_start_o,
  output logic [SD_SEC_W-1:0] rd_sec_o,
  input  logic [7:0]          rd_byte_i,
  input  logic                rd_byte_valid_i,
  input  logic                rd_done_i,
  output logic [15:0]         word_o,
  output logic                word_valid_o,
  output logic                word_src_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int GAP_W   = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  localparam logic [9:0]         BLK_CNT   = 10'(BLK_BYTES);
  localparam logic [17:0]        TMO_LAST  = 18'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GAP_LAST  = (GAP_CYC < 1) ? '0 : GAP_W'(GAP_CYC - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]          state_reg;
  req_id_t             owner_reg;
  logic [SD_SEC_W-1:0] cur_sec_reg;
  logic [11:0]         remain_reg;
  logic [9:0]          byte_cnt_reg;
  logic [17:0]         tmo_reg;
  logic [RETRY_W-1:0]  retry_reg;
  logic [GAP_W-1:0]    gap_reg;
  logic [7:0]          pack_hi_reg;
  logic [15:0]         word_reg;
  logic                word_valid_reg;
  req_id_t             word_src_reg;
  logic                err_reg;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [1:0] req_vec;
  logic       arb_valid;
  req_id_t    arb_id;
  logic       release_stb;

  assign req_vec     = {req1_i, req0_i};
  assign release_stb = (state_reg == ST_FINISH);

  sd_rr_arb2 u_arb (
    .clk         (SD_clk),
    .srst        (SD_rst),
    .req         (req_vec),
    .release_stb (release_stb),
    .release_id  (owner_reg),
    .gnt_valid   (arb_valid),
    .gnt_id      (arb_id)
  );

  logic [SD_SEC_W-1:0] grant_sec;
  logic [11:0]         grant_len;

  assign grant_sec = (arb_id == REQ_ID1) ? req1_sec_i : req0_sec_i;
  assign grant_len = (arb_id == REQ_ID1) ? req1_len_i : req0_len_i;

  // -------------------------------------------------------------------------
  // Block supervision. A byte arriving together with rd_done_i is counted
  // before the length check, hence the check uses byte_cnt_next.
  // -------------------------------------------------------------------------
  logic       in_wait;
  logic       byte_take;
  logic [9:0] byte_cnt_next;
  logic       blk_ok;
  logic       blk_fail;

  assign in_wait       = (state_reg == ST_WAIT_BLK);
  // Bytes past the block size are dropped and not counted.
  assign byte_take     = in_wait && rd_byte_valid_i && (byte_cnt_reg < BLK_CNT);
  assign byte_cnt_next = byte_cnt_reg + {9'd0, byte_take};
  assign blk_ok        = rd_done_i && (byte_cnt_next == BLK_CNT);
  // A completion in the timeout cycle still counts as a completion.
  assign blk_fail      = (rd_done_i && !blk_ok) || (!rd_done_i && (tmo_reg == TMO_LAST));

  // -------------------------------------------------------------------------
  // Main sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge SD_clk) begin
    if (SD_rst) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= REQ_ID0;
      cur_sec_reg    <= '0;
      remain_reg     <= '0;
      byte_cnt_reg   <= '0;
      tmo_reg        <= '0;
      retry_reg      <= '0;
      gap_reg        <= '0;
      pack_hi_reg    <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      word_src_reg   <= REQ_ID0;
      err_reg        <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            owner_reg   <= arb_id;
            cur_sec_reg <= grant_sec;
            remain_reg  <= grant_len;
            retry_reg   <= '0;
            err_reg     <= 1'b0;
            state_reg   <= (grant_len == 12'd0) ? ST_FINISH : ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          byte_cnt_reg <= '0;
          tmo_reg      <= '0;
          pack_hi_reg  <= '0;
          state_reg    <= ST_WAIT_BLK;
        end

        ST_WAIT_BLK: begin
          tmo_reg <= tmo_reg + 18'd1;

          if (byte_take) begin
            byte_cnt_reg <= byte_cnt_next;
            if (!byte_cnt_reg[0]) begin
              pack_hi_reg <= rd_byte_i;
            end else begin
              word_reg       <= {pack_hi_reg, rd_byte_i};
              word_valid_reg <= 1'b1;
              word_src_reg   <= owner_reg;
            end
          end

          if (blk_ok) begin
            cur_sec_reg <= cur_sec_reg + 1'b1;
            remain_reg  <= remain_reg - 12'd1;
            retry_reg   <= '0;
            gap_reg     <= '0;
            state_reg   <= ST_GAP;
          end else if (blk_fail) begin
            gap_reg <= '0;
            if (retry_reg < RETRY_MAX) begin
              // cur_sec is left alone so the same sector is re-issued.
              retry_reg <= retry_reg + 1'b1;
              state_reg <= ST_GAP;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= ST_FINISH;
            end
          end
        end

        ST_GAP: begin
          if (gap_reg == GAP_LAST) begin
            state_reg <= (remain_reg == 12'd0) ? ST_FINISH : ST_ISSUE;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end

        ST_FINISH: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Per-requester grant / done decode. Grant is dropped in the FINISH cycle,
  // the same cycle the done pulse is shown.
  // -------------------------------------------------------------------------
  logic       job_active;
  logic       owner_bit;
  logic [1:0] gnt_vec;
  logic [1:0] done_vec;

  assign job_active = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_BLK) ||
                      (state_reg == ST_GAP);
  assign owner_bit  = (owner_reg == REQ_ID1);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign gnt_vec[gi]  = job_active && (owner_bit == 1'(gi));
      assign done_vec[gi] = release_stb && (owner_bit == 1'(gi));
    end
  endgenerate

  assign gnt0_o       = gnt_vec[0];
  assign gnt1_o       = gnt_vec[1];
  assign done0_o      = done_vec[0];
  assign done1_o      = done_vec[1];

  assign rd_start_o   = (state_reg == ST_ISSUE);
  assign rd_sec_o     = cur_sec_reg;
  assign word_o       = word_reg;
  assign word_valid_o = word_valid_reg;
  assign word_src_o   = (word_src_reg == REQ_ID1);
  assign busy_o       = (state_reg != ST_IDLE);
  assign err_o        = err_reg;

endmodule

// File: tb/tb_sd_sector_sched.sv
// ---------------------------------------------------------------------------
// tb_sd_sector_sched
// Directed bench for sd_sector_sched with a behavioural block reader.
// The reader answers each rd_start_o with a byte ramp 0x00,0x01,... and
// pulses rd_done_i together with the last byte; its mode selects full
// blocks, a short first attempt, or no completion at all.
// ---------------------------------------------------------------------------
module tb_sd_sector_sched;

  localparam int GAP_CYC     = 16;
  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_RETRY   = 3;
  localparam int BLK_BYTES   = 512;

  localparam int MODE_FULL  = 0;
  localparam int MODE_SHORT = 1;
  localparam int MODE_NEVER = 2;

  logic        SD_clk;
  logic        SD_rst;
  logic        req0_i, req1_i;
  logic [31:0] req0_sec_i, req1_sec_i;
  logic [11:0] req0_len_i, req1_len_i;
  logic        gnt0_o, gnt1_o, done0_o, done1_o;
  logic        rd_start_o;
  logic [31:0] rd_sec_o;
  logic [7:0]  rd_byte_i;
  logic        rd_byte_valid_i;
  logic        rd_done_i;
  logic [15:0] word_o;
  logic        word_valid_o, word_src_o, busy_o, err_o;

  sd_sector_sched #(
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY),
    .BLK_BYTES   (BLK_BYTES)
  ) dut (
    .SD_clk          (SD_clk),
    .SD_rst          (SD_rst),
    .req0_i          (req0_i),
    .req0_sec_i      (req0_sec_i),
    .req0_len_i      (req0_len_i),
    .gnt0_o          (gnt0_o),
    .done0_o         (done0_o),
    .req1_i          (req1_i),
    .req1_sec_i      (req1_sec_i),
    .req1_len_i      (req1_len_i),
    .gnt1_o          (gnt1_o),
    .done1_o         (done1_o),
    .rd_start_o      (rd_start_o),
    .rd_sec_o        (rd_sec_o),
    .rd_byte_i       (rd_byte_i),
    .rd_byte_valid_i (rd_byte_valid_i),
    .rd_done_i       (rd_done_i),
    .word_o          (word_o),
    .word_valid_o    (word_valid_o),
    .word_src_o      (word_src_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  initial SD_clk = 1'b0;
  always #5 SD_clk = ~SD_clk;

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_start;
  logic [31:0] start_sec_q[$];
  int          start_cyc_q[$];
  int          n_words;
  logic [15:0] first_word;
  int          widx;
  int          n_done0, n_done1;
  int          done0_cyc, done1_cyc;
  logic        done_err;
  logic        exp_src;
  logic [7:0]  ehi, elo;

  int          rdr_mode    = MODE_FULL;
  int          rdr_attempt = 0;
  logic        rdr_abort   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge SD_clk) cyc <= cyc + 1;

  // Output monitor: command log, word checks, done log.
  always @(negedge SD_clk) begin
    if (rd_start_o) begin
      n_start++;
      start_sec_q.push_back(rd_sec_o);
      start_cyc_q.push_back(cyc);
      widx = 0;
    end
    if (word_valid_o) begin
      if (n_words == 0) first_word = word_o;
      n_words++;
      ehi = 8'(2 * widx);
      elo = 8'(2 * widx + 1);
      check("word_data", 32'(word_o), 32'({ehi, elo}));
      check("word_src", 32'(word_src_o), 32'(exp_src));
      widx++;
    end
    if (done0_o) begin
      n_done0++;
      done0_cyc = cyc;
      done_err  = err_o;
    end
    if (done1_o) begin
      n_done1++;
      done1_cyc = cyc;
      done_err  = err_o;
    end
  end

  // Behavioural block reader.
  initial begin
    int nb;
    rd_byte_i       = 8'h00;
    rd_byte_valid_i = 1'b0;
    rd_done_i       = 1'b0;
    forever begin
      @(negedge SD_clk);
      if (rd_start_o && !rdr_abort) begin
        nb = (rdr_mode == MODE_SHORT && rdr_attempt == 0) ? 300 : BLK_BYTES;
        rdr_attempt++;
        @(negedge SD_clk);
        for (int i = 0; i < nb && !rdr_abort; i++) begin
          rd_byte_i       = 8'(i);
          rd_byte_valid_i = 1'b1;
          rd_done_i       = (rdr_mode != MODE_NEVER) && (i == nb - 1);
          @(negedge SD_clk);
        end
        rd_byte_valid_i = 1'b0;
        rd_done_i       = 1'b0;
      end
    end
  end

  task automatic clear_log();
    n_start = 0;
    start_sec_q.delete();
    start_cyc_q.delete();
    n_words     = 0;
    first_word  = 16'h0;
    widx        = 0;
    n_done0     = 0;
    n_done1     = 0;
    done0_cyc   = 0;
    done1_cyc   = 0;
    done_err    = 1'b0;
    rdr_attempt = 0;
  endtask

  task automatic do_reset();
    @(negedge SD_clk);
    SD_rst = 1'b1;
    repeat (2) @(negedge SD_clk);
    SD_rst = 1'b0;
  endtask

  // Raise one request, hold it until its done pulse (bounded), then drop it.
  task automatic run_job(input logic id, input logic [31:0] sec, input logic [11:0] len,
                         input int budget, output int waited);
    logic seen;
    @(negedge SD_clk);
    if (id == 1'b0) begin
      req0_sec_i = sec; req0_len_i = len; req0_i = 1'b1;
    end else begin
      req1_sec_i = sec; req1_len_i = len; req1_i = 1'b1;
    end
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      @(negedge SD_clk);
      waited++;
      if ((id == 1'b0 && done0_o) || (id == 1'b1 && done1_o)) seen = 1'b1;
    end
    req0_i = 1'b0;
    req1_i = 1'b0;
    check("job_done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge SD_clk);
    $display("[TB] job req%0d sec=%0d len=%0d starts=%0d words=%0d err=%0b cycles=%0d",
             id, sec, len, n_start, n_words, done_err, waited);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int   waited;
    int   first_gnt;
    logic seen0, seen1;

    SD_rst = 1'b1;
    req0_i = 1'b0; req0_sec_i = '0; req0_len_i = '0;
    req1_i = 1'b0; req1_sec_i = '0; req1_len_i = '0;
    exp_src = 1'b0;
    clear_log();
    repeat (3) @(negedge SD_clk);
    SD_rst = 1'b0;

    // Reset state
    check("reset_flags", 32'({gnt0_o, gnt1_o, done0_o, done1_o, rd_start_o,
                              word_valid_o, word_src_o, busy_o, err_o}), 32'd0);
    check("reset_rd_sec", rd_sec_o, 32'd0);
    check("reset_word", 32'(word_o), 32'd0);

    // Two-sector job, full blocks
    clear_log();
    exp_src  = 1'b0;
    rdr_mode = MODE_FULL;
    run_job(1'b0, 32'd39928, 12'd2, 3000, waited);
    check("t1_starts", 32'(n_start), 32'd2);
    check("t1_sec0", start_sec_q[0], 32'd39928);
    check("t1_sec1", start_sec_q[1], 32'd39929);
    check("t1_start_spacing", 32'(start_cyc_q[1] - start_cyc_q[0]),
          32'(1 + BLK_BYTES + GAP_CYC));
    check("t1_words", 32'(n_words), 32'd512);
    check("t1_first_word", 32'(first_word), 32'h0001);
    check("t1_done0", 32'(n_done0), 32'd1);
    check("t1_done1", 32'(n_done1), 32'd0);
    check("t1_err", 32'(done_err), 32'd0);

    // Simultaneous requests right after reset
    do_reset();
    clear_log();
    exp_src   = 1'b0;
    first_gnt = -1;
    seen0     = 1'b0;
    seen1     = 1'b0;
    @(negedge SD_clk);
    req0_sec_i = 32'd100; req0_len_i = 12'd1; req0_i = 1'b1;
    req1_sec_i = 32'd200; req1_len_i = 12'd1; req1_i = 1'b1;
    for (int k = 0; k < 4000 && !(seen0 && seen1); k++) begin
      @(negedge SD_clk);
      if (first_gnt < 0) begin
        if (gnt0_o) first_gnt = 0;
        else if (gnt1_o) first_gnt = 1;
      end
      if (done0_o) begin seen0 = 1'b1; req0_i = 1'b0; exp_src = 1'b1; end
      if (done1_o) begin seen1 = 1'b1; req1_i = 1'b0; end
    end
    req0_i = 1'b0;
    req1_i = 1'b0;
    repeat (3) @(negedge SD_clk);
    $display("[TB] job pair sec=100/200 starts=%0d words=%0d first_gnt=%0d",
             n_start, n_words, first_gnt);
    check("t2_both_done", 32'({seen0, seen1}), 32'b11);
    check("t2_first_gnt", 32'(first_gnt), 32'd0);
    check("t2_done_order", 32'(done0_cyc < done1_cyc), 32'd1);
    check("t2_sec0", start_sec_q[0], 32'd100);
    check("t2_sec1", start_sec_q[1], 32'd200);
    check("t2_words", 32'(n_words), 32'd512);

    // Short first attempt, good retry
    clear_log();
    exp_src  = 1'b0;
    rdr_mode = MODE_SHORT;
    run_job(1'b0, 32'd5000, 12'd1, 3000, waited);
    check("t3_starts", 32'(n_start), 32'd2);
    check("t3_sec0", start_sec_q[0], 32'd5000);
    check("t3_sec1", start_sec_q[1], 32'd5000);
    check("t3_words", 32'(n_words), 32'(150 + 256));
    check("t3_done0", 32'(n_done0), 32'd1);
    check("t3_err", 32'(done_err), 32'd0);

    // Reader never completes: timeout on every attempt
    clear_log();
    exp_src  = 1'b1;
    rdr_mode = MODE_NEVER;
    run_job(1'b1, 32'd777, 12'd1, 6000, waited);
    check("t4_starts", 32'(n_start), 32'(1 + MAX_RETRY));
    for (int i = 0; i < 1 + MAX_RETRY; i++) begin
      check("t4_sec", start_sec_q[i], 32'd777);
    end
    check("t4_done1", 32'(n_done1), 32'd1);
    check("t4_err_at_done", 32'(done_err), 32'd1);
    check("t4_err_sticky", 32'(err_o), 32'd1);

    // Zero-length job
    clear_log();
    rdr_mode = MODE_FULL;
    run_job(1'b1, 32'd4242, 12'd0, 3, waited);
    check("t5_no_start", 32'(n_start), 32'd0);
    check("t5_done1", 32'(n_done1), 32'd1);
    check("t5_latency_ok", 32'(waited <= 3), 32'd1);
    check("t5_err_cleared", 32'(err_o), 32'd0);

    // Reset in the middle of a four-sector job
    clear_log();
    exp_src = 1'b0;
    @(negedge SD_clk);
    req0_sec_i = 32'd9000; req0_len_i = 12'd4; req0_i = 1'b1;
    waited = 0;
    while (n_start < 2 && waited < 3000) begin
      @(negedge SD_clk);
      waited++;
    end
    check("t6_reached_sec2", 32'(n_start), 32'd2);
    repeat (100) @(negedge SD_clk);
    SD_rst    = 1'b1;
    rdr_abort = 1'b1;
    req0_i    = 1'b0;
    @(negedge SD_clk);
    SD_rst = 1'b0;
    check("t6_rst_flags", 32'({gnt0_o, gnt1_o, done0_o, done1_o, rd_start_o,
                               word_valid_o, word_src_o, busy_o, err_o}), 32'd0);
    check("t6_rst_rd_sec", rd_sec_o, 32'd0);
    check("t6_rst_word", 32'(word_o), 32'd0);
    repeat (5) @(negedge SD_clk);
    rdr_abort = 1'b0;
    check("t6_no_done", 32'(n_done0), 32'd0);
    $display("[TB] job req0 sec=9000 len=4 aborted by reset after %0d starts", n_start);

    clear_log();
    run_job(1'b0, 32'd9000, 12'd1, 3000, waited);
    check("t6_restart_starts", 32'(n_start), 32'd1);
    check("t6_restart_sec", start_sec_q[0], 32'd9000);
    check("t6_restart_words", 32'(n_words), 32'd256);
    check("t6_restart_done", 32'(n_done0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the bench always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
